// File: rtl/mdu_ctrl_pkg.sv
// Shared MD-class opcode and FSM encodings used by the ID/EX decoders and the MDU.
package mdu_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam int CNT_W = 4;

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational mult/div datapath producing {hi, lo}; latency 0, no flow control.
// Divide by zero passes old_hi/old_lo through so the commit leaves HI/LO untouched.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] old_hi,
  input  logic [31:0] old_lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0] prod_s, prod_u;
  logic [31:0] mag_a, mag_b, div_b, q_mag, r_mag, q_sgn, r_sgn, q_u, r_u, divu_b;

  // Sign-extending to 64 bits makes the low 64 product bits the signed result.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  assign mag_a  = a[31] ? -a : a;
  assign mag_b  = b[31] ? -b : b;
  assign div_b  = (b == 32'd0) ? 32'd1 : mag_b;
  assign divu_b = (b == 32'd0) ? 32'd1 : b;
  assign q_mag  = mag_a / div_b;
  assign r_mag  = mag_a % div_b;
  assign q_sgn  = (a[31] ^ b[31]) ? -q_mag : q_mag;
  assign r_sgn  = a[31] ? -r_mag : r_mag;
  assign q_u    = a / divu_b;
  assign r_u    = a % divu_b;

  always_comb begin
    res_hi = old_hi;
    res_lo = old_lo;
    case (op)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV: if (b != 32'd0) begin
        res_hi = r_sgn;
        res_lo = q_sgn;
      end
      MD_DIVU: if (b != 32'd0) begin
        res_hi = r_u;
        res_lo = q_u;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// HI/LO mult/div sequencer: result visible MULT_CYCLES/DIV_CYCLES after start, mthi/mtlo in 1 cycle.
// No backpressure on EX; collisions are prevented upstream via the combinational stall_md request.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_start,
  input  logic [2:0]  ex_op,
  input  logic [31:0] ex_a,
  input  logic [31:0] ex_b,
  input  logic        id_md_use,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_load;
  logic [31:0]        pend_hi, pend_lo, res_hi, res_lo;
  logic               md_go;

  assign md_go    = ex_start & is_muldiv(ex_op);
  assign cnt_load = ((ex_op == MD_MULT) || (ex_op == MD_MULTU)) ? CNT_W'(MULT_CYCLES)
                                                                : CNT_W'(DIV_CYCLES);

  mdu_arith u_arith (
    .op     (ex_op),
    .a      (ex_a),
    .b      (ex_b),
    .old_hi (hi),
    .old_lo (lo),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (md_go) state_nxt = S_RUN;
      S_RUN:   if (cnt == CNT_W'(1)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // An EX-stage mthi/mtlo lands before the ID op reaches EX, so only mult/div stalls.
  always_comb begin
    busy     = (state == S_RUN);
    stall_md = id_md_use & (busy | md_go);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      hi      <= '0;
      lo      <= '0;
    end else if (state == S_IDLE) begin
      if (md_go) begin
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        cnt     <= cnt_load;
      end else if (ex_start && ex_op == MD_MTHI) begin
        hi <= ex_a;
      end else if (ex_start && ex_op == MD_MTLO) begin
        lo <= ex_a;
      end
    end else begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed, table-driven bench for mdu_ctrl plus hand-written stall and reset sequences.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_start;
  logic [2:0]  ex_op;
  logic [31:0] ex_a, ex_b;
  logic        id_md_use;
  logic        busy, stall_md;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[15];

  always #5 clk = ~clk;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .ex_start  (ex_start),
    .ex_op     (ex_op),
    .ex_a      (ex_a),
    .ex_b      (ex_b),
    .id_md_use (id_md_use),
    .busy      (busy),
    .stall_md  (stall_md),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one EX op for a single cycle, then counts busy cycles (bounded).
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int cyc);
    @(negedge clk);
    ex_start = 1'b1; ex_op = op; ex_a = a; ex_b = b;
    @(negedge clk);
    ex_start = 1'b0; ex_op = MD_NONE;
    cyc = 0;
    while (busy && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;

    vecs[0]  = '{MD_MULT,  32'hFFFFFFFD, 32'h00000004, 32'hFFFFFFFF, 32'hFFFFFFF4, 5};
    vecs[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[2]  = '{MD_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10};
    vecs[3]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[4]  = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[5]  = '{MD_MTHI,  32'h00000011, 32'h00000000, 32'h00000011, 32'hFFFFFFFD, 0};
    vecs[6]  = '{MD_MTLO,  32'h00000022, 32'h00000000, 32'h00000011, 32'h00000022, 0};
    vecs[7]  = '{MD_DIV,   32'h00000064, 32'h00000000, 32'h00000011, 32'h00000022, 10};
    vecs[8]  = '{MD_DIVU,  32'h00000005, 32'h00000000, 32'h00000011, 32'h00000022, 10};
    vecs[9]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[10] = '{MD_MTHI,  32'h0000DEAD, 32'h00000000, 32'h0000DEAD, 32'h80000000, 0};
    vecs[11] = '{MD_MTLO,  32'h0000BEEF, 32'h00000000, 32'h0000DEAD, 32'h0000BEEF, 0};
    vecs[12] = '{MD_NONE,  32'h00000123, 32'h00000456, 32'h0000DEAD, 32'h0000BEEF, 0};
    vecs[13] = '{MD_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 10};
    vecs[14] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};

    reset = 1'b0; ex_start = 1'b0; ex_op = MD_NONE; ex_a = '0; ex_b = '0; id_md_use = 1'b1;
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset stall", {31'd0, stall_md}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1; id_md_use = 1'b0;

    for (int i = 0; i < 15; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
      check($sformatf("vec%0d busy_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
      check($sformatf("vec%0d hi", i), hi, vecs[i].exp_hi);
      check($sformatf("vec%0d lo", i), lo, vecs[i].exp_lo);
    end

    // Stall window: start cycle plus every busy cycle, released when busy falls.
    @(negedge clk);
    id_md_use = 1'b1; ex_start = 1'b1; ex_op = MD_MULT; ex_a = 32'd3; ex_b = 32'd5;
    #1 check("stall start cycle", {31'd0, stall_md}, 32'd1);
    @(negedge clk);
    ex_start = 1'b0; ex_op = MD_NONE;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall busy%0d busy", k), {31'd0, busy}, 32'd1);
      check($sformatf("stall busy%0d stall", k), {31'd0, stall_md}, 32'd1);
      @(negedge clk);
    end
    check("stall end busy", {31'd0, busy}, 32'd0);
    check("stall end stall", {31'd0, stall_md}, 32'd0);
    check("stall end lo", lo, 32'd15);
    check("stall end hi", hi, 32'd0);

    // MTHI in EX with an MD op in ID must not stall.
    ex_start = 1'b1; ex_op = MD_MTHI; ex_a = 32'h0000DEAD;
    #1 check("mthi stall", {31'd0, stall_md}, 32'd0);
    @(negedge clk);
    ex_start = 1'b0; ex_op = MD_NONE; id_md_use = 1'b0;
    check("mthi busy", {31'd0, busy}, 32'd0);
    check("mthi hi", hi, 32'h0000DEAD);

    // Async reset in the middle of a divide.
    ex_start = 1'b1; ex_op = MD_DIV; ex_a = 32'd100; ex_b = 32'd7;
    @(negedge clk);
    ex_start = 1'b0; ex_op = MD_NONE;
    repeat (2) @(negedge clk);
    check("mid-div busy", {31'd0, busy}, 32'd1);
    check("mid-div hi held", hi, 32'h0000DEAD);
    #2 reset = 1'b0;
    #1;
    check("async reset busy", {31'd0, busy}, 32'd0);
    check("async reset hi", hi, 32'd0);
    check("async reset lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    do_op(MD_MULTU, 32'd2, 32'd3, cyc);
    check("post-reset multu cycles", 32'(cyc), 32'd5);
    check("post-reset multu lo", lo, 32'd6);
    check("post-reset multu hi", hi, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
